// File: rtl/transposed_fir_core.sv
// T-tap transposed-form FIR with valid/ready streaming and a double-buffered coefficient bank.
// Define FIR_SAT_EN to saturate the output (and drive sat_sticky) instead of wrapping it.
module transposed_fir_core #(
  parameter int unsigned N     = 16,
  parameter int unsigned T     = 8,
  parameter int unsigned SHIFT = 15,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  input  logic             clear_state,
  input  logic             coeff_load_start,
  input  logic             coeff_wr_valid,
  input  logic [N-1:0]     coeff_wr_data,
  output logic             coeff_busy,
  output logic             sat_sticky
);

  localparam int unsigned PROD_W = 2 * N;
  localparam int unsigned ACC_W  = 2 * N + $clog2(T);
  localparam int unsigned RND_W  = ACC_W + 1;
  localparam int unsigned EXT_W  = (OUT_W > RND_W) ? OUT_W : RND_W;
  localparam int unsigned CNT_W  = $clog2(T);
  localparam logic signed [RND_W-1:0] RND_C = RND_W'((RND_W'(1) << SHIFT) >> 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SWAP} state_t;

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic                      shadow_we;
  logic [N-1:0]              active [T];
  logic [N-1:0]              shadow [T];
  logic signed [PROD_W-1:0]  prod   [T];
  logic signed [ACC_W-1:0]   r      [1:T-1];
  logic signed [ACC_W-1:0]   r_in   [1:T-1];
  logic signed [ACC_W-1:0]   r_nx   [1:T-1];
  logic signed [ACC_W-1:0]   y;
  logic signed [RND_W-1:0]   rounded;
  logic signed [RND_W-1:0]   shifted;
  logic signed [EXT_W-1:0]   shifted_ext;
  logic [OUT_W-1:0]          reduced;
  logic                      accept;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign coeff_busy = (state != ST_IDLE);

  // Tap products and next partial sums; clear_state zeroes the incoming partial sums.
  always_comb begin
    for (int k = 0; k < T; k++) begin
      prod[k] = PROD_W'($signed(active[k])) * PROD_W'($signed(in_data));
    end
    for (int k = 1; k < T; k++) begin
      r_in[k] = clear_state ? '0 : r[k];
    end
    for (int k = 1; k < T - 1; k++) begin
      r_nx[k] = ACC_W'(prod[k]) + r_in[k+1];
    end
    r_nx[T-1] = ACC_W'(prod[T-1]);
  end

  assign y           = ACC_W'(prod[0]) + r_in[1];
  assign rounded     = RND_W'(y) + RND_C;
  assign shifted     = rounded >>> SHIFT;
  assign shifted_ext = EXT_W'(shifted);

`ifdef FIR_SAT_EN
  localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

  logic sat_hi, sat_lo;

  assign sat_hi  = shifted_ext > MAX_V;
  assign sat_lo  = shifted_ext < MIN_V;
  assign reduced = sat_hi ? OUT_W'(MAX_V) : (sat_lo ? OUT_W'(MIN_V) : OUT_W'(shifted_ext));

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_sticky <= 1'b0;
    end else if (accept && (sat_hi || sat_lo)) begin
      sat_sticky <= 1'b1;
    end
  end
`else
  logic unused_hi;

  // High bits dropped by the two's-complement wrap
  assign unused_hi  = ^shifted_ext;
  assign reduced    = OUT_W'(shifted_ext);
  assign sat_sticky = 1'b0;
`endif

  // Delay line: advances on accept, zeroed by clear_state
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k < T; k++) r[k] <= '0;
    end else if (accept) begin
      for (int k = 1; k < T; k++) r[k] <= r_nx[k];
    end else if (clear_state) begin
      for (int k = 1; k < T; k++) r[k] <= '0;
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= reduced;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Coefficient load FSM: next state
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    shadow_we = 1'b0;
    case (state)
      ST_IDLE: begin
        if (coeff_load_start) begin
          state_nx = ST_LOAD;
          cnt_nx   = '0;
        end
      end
      ST_LOAD: begin
        if (coeff_load_start) begin
          cnt_nx = '0;
        end else if (coeff_wr_valid) begin
          shadow_we = 1'b1;
          if (cnt == CNT_W'(T - 1)) begin
            state_nx = ST_SWAP;
            cnt_nx   = '0;
          end else begin
            cnt_nx = CNT_W'(cnt + 1'b1);
          end
        end
      end
      ST_SWAP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Coefficient load FSM: state, counter and both banks
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      for (int k = 0; k < T; k++) begin
        active[k] <= '0;
        shadow[k] <= '0;
      end
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (shadow_we) shadow[cnt] <= coeff_wr_data;
      if (state == ST_SWAP) begin
        for (int k = 0; k < T; k++) active[k] <= shadow[k];
      end
    end
  end

endmodule

// File: tb/tb_transposed_fir_core.sv
// Bench for transposed_fir_core: small 4-tap instance checked against a sample-history model,
// plus a default-parameter instance for the rounding / saturation path.
module tb_transposed_fir_core;

  localparam int unsigned N  = 16;
  localparam int unsigned TA = 4;
  localparam int unsigned SA = 0;
  localparam int unsigned OA = 34;
  localparam int unsigned TB = 8;
  localparam int unsigned SB = 15;
  localparam int unsigned OB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [N-1:0]  a_in_data, a_wd;
  logic [OA-1:0] a_out_data;
  logic          a_clear, a_start, a_wv, a_busy, a_sat;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [N-1:0]  b_in_data, b_wd;
  logic [OB-1:0] b_out_data;
  logic          b_clear, b_start, b_wv, b_busy, b_sat;

  transposed_fir_core #(.N(N), .T(TA), .SHIFT(SA), .OUT_W(OA)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .clear_state(a_clear), .coeff_load_start(a_start),
    .coeff_wr_valid(a_wv), .coeff_wr_data(a_wd),
    .coeff_busy(a_busy), .sat_sticky(a_sat)
  );

  transposed_fir_core #(.N(N), .T(TB), .SHIFT(SB), .OUT_W(OB)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .clear_state(b_clear), .coeff_load_start(b_start),
    .coeff_wr_valid(b_wv), .coeff_wr_data(b_wd),
    .coeff_busy(b_busy), .sat_sticky(b_sat)
  );

  int    n_pass = 0;
  int    n_fail = 0;
  int    n_total = 0;
  string phase = "init";

  // Reference state for the 4-tap instance
  bit               m_ov, m_sat, m_loading, m_swap;
  int               m_idx;
  logic [63:0]      m_od;
  logic [TA*N-1:0]  m_shadow, m_active;
  longint           hx[$];
  logic [TA*N-1:0]  hb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  function automatic longint coef(input logic [TA*N-1:0] b, input int k);
    logic [N-1:0] c;
    c = b[k*N +: N];
    return longint'($signed(c));
  endfunction

  function automatic longint reduce(input longint y, input int sh, input int ow, output bit sat);
    longint v, hi, lo;
    v = y;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    hi  = (longint'(1) << (ow - 1)) - 1;
    lo  = -(longint'(1) << (ow - 1));
    sat = 1'b0;
`ifdef FIR_SAT_EN
    if (v > hi) begin
      v = hi; sat = 1'b1;
    end else if (v < lo) begin
      v = lo; sat = 1'b1;
    end
`endif
    return v;
  endfunction

  function automatic logic [63:0] lowbits(input longint v, input int w);
    logic [63:0] u;
    u = 64'(v);
    if (w < 64) u = u & ((64'd1 << w) - 64'd1);
    return u;
  endfunction

  // One clock of the 4-tap instance: drive, predict, then check registered outputs
  task automatic step_a(input bit v, input logic [N-1:0] d, input bit ordy, input bit clr,
                        input bit st, input bit wv, input logic [N-1:0] wd);
    bit     exp_rdy, acc, sat;
    longint y, r;
    a_in_valid = v; a_in_data = d; a_out_ready = ordy; a_clear = clr;
    a_start = st; a_wv = wv; a_wd = wd;
    #1;
    exp_rdy = !m_ov || ordy;
    chk("in_ready", 64'(a_in_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    if (clr) begin
      hx.delete();
      hb.delete();
    end
    if (acc) begin
      hx.push_front(longint'($signed(d)));
      hb.push_front(m_active);
      if (hx.size() > TA) begin
        void'(hx.pop_back());
        void'(hb.pop_back());
      end
      y = 0;
      foreach (hx[i]) y += coef(hb[i], i) * hx[i];
      r = reduce(y, SA, OA, sat);
      m_od = lowbits(r, OA);
      m_ov = 1'b1;
      if (sat) m_sat = 1'b1;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    if (m_swap) begin
      m_active = m_shadow;
      m_swap   = 1'b0;
    end else if (m_loading) begin
      if (st) m_idx = 0;
      else if (wv) begin
        m_shadow[m_idx*N +: N] = wd;
        if (m_idx == TA - 1) begin
          m_loading = 1'b0;
          m_swap    = 1'b1;
        end else m_idx++;
      end
    end else if (st) begin
      m_loading = 1'b1;
      m_idx     = 0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", 64'(a_out_valid), 64'(m_ov));
    chk("out_data", 64'(a_out_data), m_od);
    chk("coeff_busy", 64'(a_busy), 64'(m_loading || m_swap));
    chk("sat_sticky", 64'(a_sat), 64'(m_sat));
  endtask

  task automatic load_a(input logic [TA*N-1:0] bank, input bit v, input logic [N-1:0] d);
    step_a(v, d, 1'b1, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < TA; k++) step_a(v, d, 1'b1, 1'b0, 1'b0, 1'b1, bank[k*N +: N]);
    step_a(v, d, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic step_b(input bit v, input logic [N-1:0] d, input bit st, input bit wv,
                        input logic [N-1:0] wd);
    b_in_valid = v; b_in_data = d; b_start = st; b_wv = wv; b_wd = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_all(input int cycles);
    reset = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_out_ready = 1; a_clear = 0; a_start = 0; a_wv = 0; a_wd = '0;
    b_in_valid = 0; b_in_data = '0; b_out_ready = 1; b_clear = 0; b_start = 0; b_wv = 0; b_wd = '0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_ov = 0; m_od = '0; m_sat = 0; m_loading = 0; m_swap = 0; m_idx = 0;
    m_shadow = '0; m_active = '0;
    hx.delete();
    hb.delete();
  endtask

  initial begin
    longint      y, r, ly;
    bit          sat, b_sticky;
    logic [N-1:0] d;

    phase = "reset";
    reset_all(3);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_sat", 64'(a_sat), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);

    phase = "load1234";
    load_a({16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, '0);

    phase = "impulse";
    step_a(1, 16'd1, 1, 0, 0, 0, '0);
    chk("imp0", 64'(a_out_data), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      step_a(1, 16'd0, 1, 0, 0, 0, '0);
      chk("imp", 64'(a_out_data), (k < 4) ? 64'(k + 1) : 64'd0);
    end

    phase = "step";
    for (int k = 0; k < 6; k++) begin
      step_a(1, 16'd1, 1, 0, 0, 0, '0);
      chk("step", 64'(a_out_data), (k < 4) ? 64'((k + 1) * (k + 2) / 2) : 64'd10);
    end
    step_a(1, 16'd0, 1, 1, 0, 0, '0);
    chk("clear_out", 64'(a_out_data), 64'd0);
    step_a(1, 16'd1, 1, 0, 0, 0, '0);
    chk("after_clear", 64'(a_out_data), 64'd1);

    phase = "backpressure";
    step_a(0, 16'd0, 1, 1, 0, 0, '0);
    step_a(1, 16'd1, 1, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      step_a(1, 16'd0, 0, 0, 0, 0, '0);
      chk("bp_hold", 64'(a_out_data), 64'd1);
      chk("bp_ready", 64'(a_in_ready), 64'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      step_a(1, 16'd0, 1, 0, 0, 0, '0);
      chk("bp_resume", 64'(a_out_data), (k < 4) ? 64'(k + 1) : 64'd0);
    end

    phase = "reload";
    step_a(0, 16'd0, 1, 1, 0, 0, '0);
    for (int k = 0; k < 5; k++) step_a(1, 16'd1, 1, 0, 0, 0, '0);
    chk("pre_reload", 64'(a_out_data), 64'd10);
    load_a({16'd2, 16'd2, 16'd2, 16'd2}, 1'b1, 16'd1);
    for (int k = 0; k < 5; k++) step_a(1, 16'd1, 1, 0, 0, 0, '0);
    chk("reload_steady", 64'(a_out_data), 64'd8);

    phase = "random";
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, 15));
      step_a($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
             $urandom_range(0, 31) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 1) == 1, N'($urandom));
    end

    phase = "reset_mid_load";
    step_a(0, 16'd0, 1, 0, 1, 0, '0);
    step_a(0, 16'd0, 1, 0, 0, 1, 16'd7);
    step_a(1, 16'd3, 1, 0, 0, 1, 16'd9);
    reset_all(1);
    chk("rml_busy", 64'(a_busy), 64'd0);
    chk("rml_valid", 64'(a_out_valid), 64'd0);
    for (int k = 0; k < 6; k++) begin
      step_a(1, N'($urandom), 1, 0, 0, 0, '0);
      chk("rml_zero", 64'(a_out_data), 64'd0);
    end

    phase = "saturation";
    chk("b_rst_sat", 64'(b_sat), 64'd0);
    step_b(0, '0, 1, 0, '0);
    for (int k = 0; k < TB; k++) step_b(0, '0, 0, 1, 16'h7FFF);
    chk("b_busy_swap", 64'(b_busy), 64'd1);
    step_b(0, '0, 0, 0, '0);
    chk("b_busy_idle", 64'(b_busy), 64'd0);
    b_sticky = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      step_b(1, 16'h7FFF, 0, 0, '0);
      y = longint'((m < TB) ? m : TB) * 64'sd32767 * 64'sd32767;
      r = reduce(y, SB, OB, sat);
      if (sat) b_sticky = 1'b1;
      chk("b_valid", 64'(b_out_valid), 64'd1);
      chk("b_data", 64'(b_out_data), lowbits(r, OB));
      chk("b_sticky", 64'(b_sat), 64'(b_sticky));
    end
    ly = 64'sd8589410312;
    chk("b_full_sum", 64'(ly), 64'(longint'(TB) * 64'sd32767 * 64'sd32767));
`ifdef FIR_SAT_EN
    chk("b_sat_final", 64'(b_out_data), 64'h7FFF);
    chk("b_sticky_final", 64'(b_sat), 64'd1);
`else
    chk("b_wrap_final", 64'(b_out_data), 64'hFFF0);
    chk("b_sticky_final", 64'(b_sat), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/transposed_fir_core.md
Name: transposed_fir_core

Overview:
Parametrised T-tap transposed-form FIR filter with valid/ready streaming on input and output. Each tap multiplies the current sample and adds the registered partial sum from the tap above. A double-buffered coefficient bank is loaded serially by a small FSM while filtering continues, then swapped atomically. The output is rounded, right-shifted and width-reduced. This block replaces hand-chained single-tap blocks inside the FIR IP.

Parameters:
N, 16, sample and coefficient width (signed two's complement)
T, 8, number of taps (>=2)
SHIFT, 15, arithmetic right shift applied to accumulator before output (0 = none)
OUT_W, 16, output width
(local) ACC_W = 2*N + clog2(T), accumulator/partial-sum width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  sample valid
in_data  input  N  signed sample
in_ready  output  1  block can accept sample this cycle
out_valid  output  1  out_data valid
out_data  output  OUT_W  signed filtered sample
out_ready  input  1  downstream accepts output
clear_state  input  1  zero delay line, coefficients kept
coeff_load_start  input  1  begin coefficient load
coeff_wr_valid  input  1  coefficient word valid
coeff_wr_data  input  N  signed coefficient, c[0] first
coeff_busy  output  1  load in progress (LOAD or SWAP state)
sat_sticky  output  1  sticky saturation flag (see Optional Feature)

Behaviour:
- Reset: active and shadow banks = 0, partial sums r[1..T-1] = 0, FSM = IDLE, load counter = 0, out_valid = 0, out_data = 0, coeff_busy = 0, sat_sticky = 0. Reset during a load aborts it; both banks are cleared.
- in_ready = !out_valid || out_ready (combinational). accept = in_valid && in_ready.
- On accept with sample x and active coefficients c[k]:
  - y = c[0]*x + r[1]
  - r[k] <= c[k]*x + r[k+1] for k = 1..T-2
  - r[T-1] <= c[T-1]*x
  - Products are full 2N-bit signed. Sums are sign-extended to ACC_W, so there is no internal overflow.
- The delay line advances only on accept. It holds otherwise.
- Output stage:
  - On accept: out_data <= reduce(y), out_valid <= 1. Latency is 1 cycle from accept to out_valid.
  - If out_valid && out_ready with no accept, out_valid <= 0 and out_data holds.
  - While out_valid && !out_ready, out_data is stable.
- reduce(y):
  - If SHIFT > 0, add 2^(SHIFT-1) (round half up), then arithmetic shift right by SHIFT.
  - Then fit to OUT_W by saturating or wrapping (see Optional Feature).
- clear_state: on a cycle with clear_state = 1, all r[k] <= 0. Coefficients and the output register are unchanged.
  - If clear_state and accept occur in the same cycle, the sample is computed with r = 0 (y = c[0]*x) and then r[k] <= c[k]*x + r[k+1], with r[k+1] taken as 0.
- Coefficient FSM states:
  - IDLE: coeff_load_start -> LOAD, counter <= 0. coeff_wr_valid is ignored.
  - LOAD: each coeff_wr_valid writes shadow[counter] and increments the counter. The write of index T-1 -> SWAP.
    - coeff_load_start in LOAD restarts: counter <= 0, and words already written are overwritten later.
    - If coeff_load_start and coeff_wr_valid arrive together, the restart wins and the word is dropped.
  - SWAP: active <= shadow in one cycle, then -> IDLE.
    - A sample accepted on the SWAP cycle uses the old bank.
    - Samples accepted from the next cycle onward use the new bank.
    - Existing partial sums are not recomputed, so the transition is mixed for T-1 outputs.
- coeff_busy = 1 in LOAD and SWAP.
- Filtering is never stalled by the FSM.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined:
  - Results outside [-2^(OUT_W-1), 2^(OUT_W-1)-1] clamp to the nearest bound.
  - Any clamp sets sat_sticky <= 1.
  - sat_sticky clears only on reset.
- Undefined:
  - The low OUT_W bits are taken (two's-complement wrap).
  - sat_sticky is tied 0.
  - No comparator logic is synthesised.

Test Plan:
- Impulse, override N=16, T=4, SHIFT=0, OUT_W=34. Load coeffs 1,2,3,4, then inputs 1,0,0,0,0 with out_ready = 1 -> out_data 1,2,3,4,0, each 1 cycle after accept.
- Step, same config. Inputs 1 x6 -> 1,3,6,10,10,10. Then pulse clear_state with input 0 -> 0.
- Backpressure, same config. Hold out_ready = 0 for 3 cycles with out_valid = 1 and in_valid = 1 -> in_ready = 0, out_data held, r unchanged. On release the stream continues with no sample lost or duplicated (impulse sequence intact).
- Mid-stream reload, same config. Running with coeffs 1,2,3,4 and constant input 1 (output 10), load 2,2,2,2 -> coeff_busy high for 5 cycles. After swap, settling outputs are mixed and steady state is 8.
- Saturation, defaults (N=16, T=8, SHIFT=15, OUT_W=16). All coeffs 0x7FFF, input 0x7FFF sustained -> with FIR_SAT_EN, out_data = 0x7FFF and sat_sticky = 1. Without it, out_data = the wrapped low 16 bits and sat_sticky = 0.
- Reset mid-load. Assert reset after 2 of 4 coeff words -> next cycle coeff_busy = 0 and out_valid = 0. Subsequent inputs yield out_data = 0 until a new load completes.
